// File: rtl/context_memory.sv
// -----------------------------------------------------------------------------
// context_memory
//
// Context-variable store for the JPEG-LS regular/run modes. Holds the A, B, C,
// N and Nn variables for every context index Q, feeding the stage-4 context
// select mux and taking write-back of updated variables from the update stage.
// After reset, and on every start pulse, the whole array is walked once and
// filled with the JPEG-LS default context {A_INIT, 0, 0, 1, 0}. This takes
// exactly CONTEXTS cycles.
//
// Optional feature (macro CTXMEM_OOR_EN): adds the sticky oor_err output. It
// flags any READY-state read or write whose index is >= CONTEXTS. It is cleared
// by rst or start.
//
// Ports
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   start                    one-cycle pulse: new image, re-initialise contexts
//   init_done                high once the memory is initialised and usable
//   rd_en, Q_3               read request and context index (stage 3)
//   valid_4, Q_4             read result valid (1-cycle latency) and its index
//   A_4..Nn_4                read data (stage 4)
//   bypass_4                 read data came from a same-cycle write (write-through)
//   wr_en, Q_Updated         write-back strobe and index
//   A_Updated..Nn_Updated    write-back data
//   oor_err                  (CTXMEM_OOR_EN only) sticky out-of-range flag
// -----------------------------------------------------------------------------
module context_memory #(
    parameter int Q_length  = 9,
    parameter int A_length  = 16,
    parameter int B_length  = 16,
    parameter int C_length  = 8,
    parameter int N_length  = 7,
    parameter int Nn_length = 7,
    parameter int CONTEXTS  = 367,
    parameter int A_INIT    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 init_done,
    input  logic                 rd_en,
    input  logic [Q_length-1:0]  Q_3,
    output logic                 valid_4,
    output logic [Q_length-1:0]  Q_4,
    output logic [A_length-1:0]  A_4,
    output logic [B_length-1:0]  B_4,
    output logic [C_length-1:0]  C_4,
    output logic [N_length-1:0]  N_4,
    output logic [Nn_length-1:0] Nn_4,
    output logic                 bypass_4,
    input  logic                 wr_en,
    input  logic [Q_length-1:0]  Q_Updated,
    input  logic [A_length-1:0]  A_Updated,
    input  logic [B_length-1:0]  B_Updated,
    input  logic [C_length-1:0]  C_Updated,
    input  logic [N_length-1:0]  N_Updated,
    input  logic [Nn_length-1:0] Nn_Updated
`ifdef CTXMEM_OOR_EN
    ,
    output logic                 oor_err
`endif
);

    localparam int W = A_length + B_length + C_length + N_length + Nn_length;

    // Index limit widened by one bit so the comparison cannot wrap.
    localparam logic [Q_length:0]   CTX_LIM  = (Q_length+1)'(CONTEXTS);
    localparam logic [Q_length-1:0] LAST_IDX = Q_length'(CONTEXTS - 1);

    localparam logic [W-1:0] INIT_WORD = {A_length'(A_INIT), B_length'(0),
                                          C_length'(0), N_length'(1),
                                          Nn_length'(0)};

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t              state_reg, state_next;
    logic [Q_length-1:0] cnt_reg, cnt_next;

    // -------------------------------------------------------------------------
    // Init / service state machine
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_INIT;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_INIT: begin
                if (start) begin
                    cnt_next = '0;
                end else if (cnt_reg == LAST_IDX) begin
                    state_next = ST_READY;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_READY: begin
                if (start) begin
                    state_next = ST_INIT;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = ST_INIT;
                cnt_next   = '0;
            end
        endcase
    end

    logic ready;
    assign ready     = (state_reg == ST_READY);
    assign init_done = ready;

    // -------------------------------------------------------------------------
    // Request qualification
    // -------------------------------------------------------------------------
    logic rd_in_range, wr_in_range, rd_fire, wr_fire, hit;
    logic [W-1:0] upd_word;

    assign rd_in_range = ({1'b0, Q_3} < CTX_LIM);
    assign wr_in_range = ({1'b0, Q_Updated} < CTX_LIM);
    // start pre-empts both ports: the image is about to be re-initialised.
    assign rd_fire     = ready && rd_en && !start;
    assign wr_fire     = ready && wr_en && !start && wr_in_range;
    // wr_fire implies an in-range index, so a hit is always an in-range read.
    assign hit         = wr_fire && (Q_Updated == Q_3);
    assign upd_word    = {A_Updated, B_Updated, C_Updated, N_Updated, Nn_Updated};

    // -------------------------------------------------------------------------
    // Single write port, shared by the init walk and normal write-back.
    // -------------------------------------------------------------------------
    logic                mem_we;
    logic [Q_length-1:0] mem_waddr;
    logic [W-1:0]        mem_wdata;

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = cnt_reg;
        mem_wdata = INIT_WORD;
        if (!ready) begin
            mem_we = 1'b1;
        end else if (wr_fire) begin
            mem_we    = 1'b1;
            mem_waddr = Q_Updated;
            mem_wdata = upd_word;
        end
    end

    logic [W-1:0] mem [0:CONTEXTS-1];
    logic [W-1:0] ram_q_reg;

    // Read-first RAM. A same-address collision is resolved outside the RAM
    // through alt_word_reg, so the stale read data here is simply not selected.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
        if (rd_fire && rd_in_range) begin
            ram_q_reg <= mem[Q_3];
        end
    end

    // -------------------------------------------------------------------------
    // Stage-4 output registers. The data output comes either from the RAM read
    // register or from alt_word_reg. alt_word_reg carries the write-through
    // word, the out-of-range default, or zero after reset. Both sources load
    // only on a fired read, so the data holds while rd_en is low.
    // -------------------------------------------------------------------------
    logic [W-1:0] alt_word_reg;
    logic         src_alt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_4      <= 1'b0;
            bypass_4     <= 1'b0;
            Q_4          <= '0;
            alt_word_reg <= '0;
            src_alt_reg  <= 1'b1;
        end else begin
            valid_4  <= rd_fire;
            bypass_4 <= rd_fire && hit;
            if (rd_fire) begin
                Q_4 <= Q_3;
                if (!rd_in_range) begin
                    alt_word_reg <= INIT_WORD;
                    src_alt_reg  <= 1'b1;
                end else if (hit) begin
                    alt_word_reg <= upd_word;
                    src_alt_reg  <= 1'b1;
                end else begin
                    src_alt_reg  <= 1'b0;
                end
            end
        end
    end

    logic [W-1:0] out_word;
    assign out_word = src_alt_reg ? alt_word_reg : ram_q_reg;
    assign {A_4, B_4, C_4, N_4, Nn_4} = out_word;

`ifdef CTXMEM_OOR_EN
    // Sticky out-of-range indication. It is only raised for requests that
    // would otherwise have been serviced (READY state).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oor_err <= 1'b0;
        end else if (start) begin
            oor_err <= 1'b0;
        end else if (ready && ((rd_en && !rd_in_range) || (wr_en && !wr_in_range))) begin
            oor_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_context_memory.sv
module tb_context_memory;

    localparam int CTX = 367;
    localparam int W   = 54;
    localparam logic [W-1:0] DFLT = {16'd4, 16'd0, 8'd0, 7'd1, 7'd0};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       rd_en = 1'b0;
    logic       wr_en = 1'b0;
    logic [8:0] Q_3 = '0;
    logic [8:0] Q_Updated = '0;
    logic [15:0] A_Updated = '0, B_Updated = '0;
    logic [7:0]  C_Updated = '0;
    logic [6:0]  N_Updated = '0, Nn_Updated = '0;

    logic        init_done, valid_4, bypass_4;
    logic [8:0]  Q_4;
    logic [15:0] A_4, B_4;
    logic [7:0]  C_4;
    logic [6:0]  N_4, Nn_4;
`ifdef CTXMEM_OOR_EN
    logic        oor_err;
`endif

    context_memory dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .init_done  (init_done),
        .rd_en      (rd_en),
        .Q_3        (Q_3),
        .valid_4    (valid_4),
        .Q_4        (Q_4),
        .A_4        (A_4),
        .B_4        (B_4),
        .C_4        (C_4),
        .N_4        (N_4),
        .Nn_4       (Nn_4),
        .bypass_4   (bypass_4),
        .wr_en      (wr_en),
        .Q_Updated  (Q_Updated),
        .A_Updated  (A_Updated),
        .B_Updated  (B_Updated),
        .C_Updated  (C_Updated),
        .N_Updated  (N_Updated),
        .Nn_Updated (Nn_Updated)
`ifdef CTXMEM_OOR_EN
        ,
        .oor_err    (oor_err)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Behavioural reference model. The memory is treated as a plain array that
    // becomes all-default at the moment initialisation completes. Initialisation
    // completes CTX clock edges after reset release or after a start.
    // ------------------------------------------------------------------------
    logic [W-1:0] m_mem [CTX];
    bit           m_ready = 0;
    int           m_left  = CTX;
    bit           m_valid = 0;
    bit           m_byp   = 0;
    logic [8:0]   m_q     = '0;
    logic [W-1:0] m_word  = '0;
    bit           m_oor   = 0;

    wire [W-1:0] upd_word = {A_Updated, B_Updated, C_Updated, N_Updated, Nn_Updated};

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ready = 0; m_left = CTX; m_valid = 0; m_byp = 0;
            m_q = '0; m_word = '0; m_oor = 0;
        end else if (m_ready) begin
            if (start) begin
                m_ready = 0; m_left = CTX; m_valid = 0; m_byp = 0; m_oor = 0;
            end else begin
                m_valid = rd_en;
                m_byp   = 0;
                if (rd_en) begin
                    m_q = Q_3;
                    if (int'(Q_3) >= CTX) m_word = DFLT;
                    else if (wr_en && Q_Updated == Q_3) begin
                        m_word = upd_word; m_byp = 1;
                    end else m_word = m_mem[Q_3];
                end
                if (wr_en && int'(Q_Updated) < CTX) m_mem[Q_Updated] = upd_word;
                if ((rd_en && int'(Q_3) >= CTX) || (wr_en && int'(Q_Updated) >= CTX)) m_oor = 1;
            end
        end else begin
            m_valid = 0; m_byp = 0;
            if (start) begin
                m_left = CTX; m_oor = 0;
            end else begin
                m_left--;
            end
            if (m_left == 0) begin
                m_ready = 1;
                for (int i = 0; i < CTX; i++) m_mem[i] = DFLT;
            end
        end
    end

    // One compare process, every cycle, on the falling edge.
    always @(negedge clk) begin
        check("init_done", init_done, m_ready);
        check("valid_4", valid_4, m_valid);
        check("bypass_4", bypass_4, m_byp);
        check("Q_4", Q_4, m_q);
        check("data_4", {A_4, B_4, C_4, N_4, Nn_4}, m_word);
`ifdef CTXMEM_OOR_EN
        check("oor_err", oor_err, m_oor);
`endif
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers: inputs change 1 time unit after the rising edge.
    // ------------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_init(input string name);
        int cnt = 0;
        while (!init_done && cnt < 1000) begin
            step();
            cnt++;
        end
        check(name, cnt, CTX);
    endtask

    task automatic rd(input logic [8:0] q);
        rd_en = 1'b1; Q_3 = q;
        step();
        rd_en = 1'b0;
        $display("read  Q=%0d -> valid=%0b A=%0d B=%0h C=%0h N=%0d Nn=%0d byp=%0b",
                 q, valid_4, A_4, B_4, C_4, N_4, Nn_4, bypass_4);
    endtask

    task automatic set_upd(input logic [8:0] q, input logic [15:0] a, input logic [15:0] b,
                           input logic [7:0] c, input logic [6:0] n, input logic [6:0] nn);
        Q_Updated = q; A_Updated = a; B_Updated = b; C_Updated = c;
        N_Updated = n; Nn_Updated = nn;
    endtask

    task automatic wr(input logic [8:0] q, input logic [15:0] a, input logic [15:0] b,
                      input logic [7:0] c, input logic [6:0] n, input logic [6:0] nn);
        set_upd(q, a, b, c, n, nn);
        wr_en = 1'b1;
        step();
        wr_en = 1'b0;
        $display("write Q=%0d A=%0d B=%0h C=%0h N=%0d Nn=%0d", q, a, b, c, n, nn);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
        $display("start pulse, init_done=%0b", init_done);
    endtask

    function automatic logic [8:0] pick_q();
        case ($urandom % 4)
            0, 1:    return 9'($urandom % 8);
            2:       return 9'(360 + $urandom % 12);
            default: return 9'($urandom);
        endcase
    endfunction

    initial begin
        // Reset and first initialisation
        repeat (3) step();
        rst = 1'b0;
        check("reset_valid", valid_4, 1'b0);
        check("reset_A", A_4, 16'd0);
        wait_init("init_len_after_reset");

        // Default contents
        foreach (m_q[i]) ; // no-op to keep the style uniform
        rd(9'd0);
        check("dflt0_valid", valid_4, 1'b1);
        check("dflt0_A", A_4, 16'd4);
        check("dflt0_N", N_4, 7'd1);
        rd(9'd200);
        check("dflt200_A", A_4, 16'd4);
        check("dflt200_B", B_4, 16'd0);
        rd(9'd366);
        check("dflt366_C", C_4, 8'd0);
        check("dflt366_Nn", Nn_4, 7'd0);
        check("dflt366_Q", Q_4, 9'd366);

        // Write then read back
        wr(9'd17, 16'd100, 16'hFFFB, 8'hFD, 7'd9, 7'd2);
        rd(9'd17);
        check("q17_A", A_4, 16'd100);
        check("q17_B", B_4, 16'hFFFB);
        check("q17_C", C_4, 8'hFD);
        check("q17_N", N_4, 7'd9);
        check("q17_Nn", Nn_4, 7'd2);
        check("q17_byp", bypass_4, 1'b0);

        // Write-through on same index, independent access on different index
        set_upd(9'd40, 16'd77, 16'd1, 8'd2, 7'd3, 7'd4);
        wr_en = 1'b1;
        rd(9'd40);
        check("wt40_A", A_4, 16'd77);
        check("wt40_byp", bypass_4, 1'b1);
        wr_en = 1'b1;
        rd(9'd41);
        wr_en = 1'b0;
        check("wt41_A", A_4, 16'd4);
        check("wt41_byp", bypass_4, 1'b0);

        // New image wipes contents
        pulse_start();
        check("start_init_done", init_done, 1'b0);
        wait_init("init_len_after_start");
        rd(9'd17);
        check("wipe17_A", A_4, 16'd4);
        check("wipe17_N", N_4, 7'd1);
        check("wipe17_B", B_4, 16'd0);

        // Reset in the middle of INIT, reads ignored throughout
        pulse_start();
        rd_en = 1'b1; Q_3 = 9'd5;
        repeat (100) step();
        check("mid_init_valid", valid_4, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        wait_init("init_len_after_mid_reset");
        rd_en = 1'b0;

        // Out-of-range index
        wr(9'd400, 16'd9, 16'd9, 8'd9, 7'd9, 7'd9);
`ifdef CTXMEM_OOR_EN
        check("oor_after_wr", oor_err, 1'b1);
`endif
        rd(9'd400);
        check("oor_rd_valid", valid_4, 1'b1);
        check("oor_rd_A", A_4, 16'd4);
        check("oor_rd_N", N_4, 7'd1);
        step();
`ifdef CTXMEM_OOR_EN
        check("oor_holds", oor_err, 1'b1);
`endif
        pulse_start();
`ifdef CTXMEM_OOR_EN
        check("oor_cleared", oor_err, 1'b0);
`endif
        wait_init("init_len_before_random");

        // Randomised traffic checked by the model every cycle
        for (int i = 0; i < 3000; i++) begin
            rd_en = 1'($urandom % 2);
            wr_en = 1'($urandom % 2);
            Q_3   = pick_q();
            set_upd((($urandom % 3) == 0) ? Q_3 : pick_q(),
                    16'($urandom), 16'($urandom), 8'($urandom), 7'($urandom), 7'($urandom));
            start = (($urandom % 1000) == 0);
            step();
            $display("rand %0d rd=%0b Q3=%0d wr=%0b Qu=%0d st=%0b -> valid=%0b Q4=%0d A=%0d byp=%0b",
                     i, rd_en, Q_3, wr_en, Q_Updated, start, valid_4, Q_4, A_4, bypass_4);
        end
        rd_en = 1'b0; wr_en = 1'b0; start = 1'b0;
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/context_memory.md
Name: context_memory

Overview:
- Context-variable store for the JPEG-LS regular/run modes. Holds A, B, C, N and Nn for every context index Q.
- Sits directly upstream of the stage-4 context select mux. Takes the stage-3 context index, returns registered stage-4 variables (Q_4..Nn_4), and accepts write-back of the updated variables from the update stage.
- Self-initialises all contexts to JPEG-LS defaults after reset and on each new image.

Parameters:
- Q_length, 9, width of context index
- A_length, 16, width of A
- B_length, 16, width of B (two's complement)
- C_length, 8, width of C (two's complement)
- N_length, 7, width of N
- Nn_length, 7, width of Nn
- CONTEXTS, 367, number of stored contexts (365 regular + 2 run)
- A_INIT, 4, reset value of A, i.e. max(2,(RANGE+32)/64) for 8-bit

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle pulse: new image, re-initialise all contexts
- init_done  out  1  high when memory is initialised and usable
- rd_en  in  1  read request for Q_3 this cycle
- Q_3  in  Q_length  context index to read
- valid_4  out  1  Q_4..Nn_4 valid (1-cycle read latency)
- Q_4  out  Q_length  registered copy of Q_3
- A_4 / B_4 / C_4 / N_4 / Nn_4  out  respective widths  read data
- bypass_4  out  1  read data came from a same-cycle write (write-through)
- wr_en  in  1  write-back strobe
- Q_Updated  in  Q_length  write address
- A_Updated / B_Updated / C_Updated / N_Updated / Nn_Updated  in  respective widths  write data

Behaviour:
- Reset (async, rst=1):
  - valid_4, bypass_4 and init_done = 0.
  - Q_4..Nn_4 = 0.
  - FSM enters INIT with init counter = 0.
- FSM states: INIT, READY.
  - INIT: each cycle writes {A_INIT, 0, 0, 1, 0} to entry[counter], then counter++.
  - When counter = CONTEXTS-1 is written, go to READY. init_done rises the following cycle, so the init sequence takes exactly CONTEXTS cycles.
  - READY: normal service. start=1 → INIT with counter = 0 and init_done = 0 on the next edge.
  - start=1 while in INIT restarts the counter at 0.
- During INIT:
  - rd_en and wr_en are ignored.
  - valid_4 = 0.
- Read (READY, rd_en=1): on the next edge, valid_4=1, Q_4=Q_3, and the data outputs take entry[Q_3]. rd_en=0 gives valid_4=0 next cycle; data outputs hold their last values.
- Write (READY, wr_en=1): entry[Q_Updated] takes the Updated values at the edge.
- Same-cycle read and write to the same index: the read returns the Updated values (write-through) and bypass_4=1. In every other case bypass_4=0.
- Same-cycle read and write to different indices: both complete independently.
- start and wr_en in the same cycle: the write is dropped and INIT wins. A read in the same cycle also returns valid_4=0.
- Q ≥ CONTEXTS:
  - Writes are dropped.
  - Reads return {A_INIT, 0, 0, 1, 0} with valid_4=1.
- No arithmetic is performed; all values are stored verbatim at their declared widths.
- Storage is one register/RAM array of width A+B+C+N+Nn bits with a single write port. The init writes and normal writes share that port through a mux.

Optional Feature:
- Macro: CTXMEM_OOR_EN.
- Defined: adds output oor_err (1 bit).
  - Sticky set the cycle after any rd_en or wr_en (READY only) with index ≥ CONTEXTS.
  - Cleared by rst or start.
- Undefined:
  - No oor_err port.
  - Out-of-range handling is as stated above, with no indication.

Test Plan:
- Release rst, idle → init_done=0 for 367 cycles, =1 on cycle 368. Read Q_3=0, 200 and 366 → A_4=4, B_4=0, C_4=0, N_4=1, Nn_4=0, valid_4=1 one cycle after each.
- Write Q=17 with A=100, B=-5, C=-3, N=9, Nn=2. Next cycle read Q_3=17 → same values, bypass_4=0.
- Same cycle: wr_en Q=40 with A=77, rd_en Q_3=40 → next cycle A_4=77, bypass_4=1. Repeat with Q_3=41 → A_4=4, bypass_4=0.
- After the writes above, pulse start → init_done=0 for 367 cycles. Read Q=17 → A_4=4, N_4=1, B_4=0.
- Assert rst mid-INIT at counter 100, release → full 367-cycle INIT restarts; rd_en during INIT → valid_4 stays 0.
- Write Q=400 then read Q_3=400 → A_4=4, N_4=1. With CTXMEM_OOR_EN defined, oor_err=1 after the write and holds until start.
